// File: rtl/trdb_stream_arbiter.sv
// Merges NSRC non-backpressured trace word streams into one valid/ready stream
// via per-source FIFOs and a round-robin output stage. Build option: TRDB_ARB_OVERFLOW_MARKER_EN.
module trdb_stream_arbiter #(
  parameter int unsigned NSRC       = 4,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned SRCW      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NSRC*XLEN-1:0] src_word_i,
  input  logic [NSRC-1:0]      src_valid_i,
  output logic [XLEN-1:0]      out_word_o,
  output logic [SRCW-1:0]      out_src_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [NSRC-1:0]      overflow_o,
  input  logic                 clear_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [XLEN-1:0] r_mem    [NSRC][FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr [NSRC];
  logic [AW:0]     r_rd_ptr [NSRC];
  logic [NSRC-1:0] r_overflow;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_word;
  logic [SRCW-1:0] r_out_src;
  logic [SRCW-1:0] r_rr;

  logic [NSRC-1:0] w_empty, w_full, w_push, w_pop, w_drop;
  logic [XLEN-1:0] w_push_word [NSRC];
  logic [SRCW-1:0] w_grant, w_idx;
  logic            w_any, w_load, w_space;

`ifdef TRDB_ARB_OVERFLOW_MARKER_EN
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] w_arm;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_empty[i] = (r_wr_ptr[i] == r_rd_ptr[i]);
      w_full[i]  = (r_wr_ptr[i][AW] != r_rd_ptr[i][AW]) &&
                   (r_wr_ptr[i][AW-1:0] == r_rd_ptr[i][AW-1:0]);
    end
  end

  // NOTE: combinational blocks assign a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    w_load  = !r_out_valid || out_ready_i;
    w_any   = |(~w_empty);
    w_grant = '0;
    w_idx   = '0;
    // Scanning downward lets the lowest offset from r_rr win the final write.
    for (int k = NSRC - 1; k >= 0; k--) begin
      w_idx = SRCW'((int'(r_rr) + k) % int'(NSRC));
      if (!w_empty[w_idx]) w_grant = w_idx;
    end
    w_pop = '0;
    if (w_load && w_any) w_pop[w_grant] = 1'b1;
  end

  always_comb begin
    w_push  = '0;
    w_drop  = '0;
    w_space = 1'b0;
`ifdef TRDB_ARB_OVERFLOW_MARKER_EN
    w_arm   = '0;
`endif
    for (int i = 0; i < NSRC; i++) begin
      w_push_word[i] = src_word_i[i*XLEN +: XLEN];
      w_space        = !w_full[i] || w_pop[i];
`ifdef TRDB_ARB_OVERFLOW_MARKER_EN
      // A pending marker takes the first free slot ahead of any live word.
      w_push[i] = w_space && (src_valid_i[i] || r_pending[i]);
      w_drop[i] = src_valid_i[i] && (!w_space || r_pending[i]);
      w_arm[i]  = src_valid_i[i] && !w_space;
      if (r_pending[i]) w_push_word[i] = {{(XLEN-8){1'b1}}, 8'(i)};
`else
      w_push[i] = w_space && src_valid_i[i];
      w_drop[i] = src_valid_i[i] && !w_space;
`endif
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the pointers alone define
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NSRC; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i][AW-1:0]] <= w_push_word[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NSRC; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
      end
      r_overflow  <= '0;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_src   <= '0;
      r_rr        <= '0;
`ifdef TRDB_ARB_OVERFLOW_MARKER_EN
      r_pending   <= '0;
`endif
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
      end
      // A drop in the same cycle as clear_i still leaves the flag set.
      r_overflow <= (r_overflow & ~{NSRC{clear_i}}) | w_drop;
`ifdef TRDB_ARB_OVERFLOW_MARKER_EN
      r_pending  <= (r_pending & ~{NSRC{clear_i}} & ~w_push) | w_arm;
`endif
      if (w_load) begin
        r_out_valid <= w_any;
        if (w_any) begin
          r_out_word <= r_mem[w_grant][r_rd_ptr[w_grant][AW-1:0]];
          r_out_src  <= w_grant;
          r_rr       <= (w_grant == SRCW'(NSRC - 1)) ? '0 : w_grant + 1'b1;
        end
      end
    end
  end

  assign out_word_o  = r_out_word;
  assign out_src_o   = r_out_src;
  assign out_valid_o = r_out_valid;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_trdb_stream_arbiter.sv
// Directed self-checking bench for trdb_stream_arbiter (NSRC=4, XLEN=32, depth 4).
module tb_trdb_stream_arbiter;

  localparam int NSRC = 4;
  localparam int XLEN = 32;
  localparam int SRCW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NSRC*XLEN-1:0] src_word = '0;
  logic [NSRC-1:0]      src_valid = '0;
  logic [XLEN-1:0]      out_word;
  logic [SRCW-1:0]      out_src;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [NSRC-1:0]      overflow;
  logic                 clear = 1'b0;
  logic [XLEN+SRCW:0]   obs;

  int n_cmp = 0;
  int n_err = 0;

  trdb_stream_arbiter #(.NSRC(NSRC), .XLEN(XLEN), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_word_i(src_word), .src_valid_i(src_valid),
    .out_word_o(out_word), .out_src_o(out_src), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .overflow_o(overflow), .clear_i(clear)
  );

  always #5 clk = ~clk;
  assign obs = {out_valid, out_src, out_word};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; src_valid = '0; clear = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    step(); step();
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL reset_out: got %h want 0", obs); end
    n_cmp++;
    if (overflow !== 4'b0000) begin n_err++; $display("FAIL reset_ovf: got %b want 0000", overflow); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    src_word[2*XLEN +: XLEN] = 32'h1234_5678;
    src_valid = 4'b0100;
    step();
    src_valid = '0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_t1: got valid %b want 0", out_valid); end
    step();
    n_cmp++;
    if (obs !== {1'b1, 2'd2, 32'h1234_5678}) begin
      n_err++; $display("FAIL single_t2: got %h want %h", obs, {1'b1, 2'd2, 32'h1234_5678});
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_t3: got valid %b want 0", out_valid); end
    n_cmp++;
    if (overflow !== 4'b0000) begin n_err++; $display("FAIL single_ovf: got %b want 0000", overflow); end
  endtask

  task automatic test_fairness();
    logic [XLEN+SRCW:0] exp;
    do_reset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 3) begin
        src_valid = 4'b1111;
        for (int s = 0; s < NSRC; s++)
          src_word[s*XLEN +: XLEN] = 32'hA000_0000 | (32'(s) << 8) | 32'(cyc);
      end else begin
        src_valid = '0;
      end
      step();
      if (cyc == 0 || cyc == 13) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL fair_idle_c%0d: got valid %b want 0", cyc, out_valid);
        end
      end else begin
        exp = {1'b1, 2'((cyc - 1) % 4),
               32'hA000_0000 | (32'((cyc - 1) % 4) << 8) | 32'((cyc - 1) / 4)};
        n_cmp++;
        if (obs !== exp) begin n_err++; $display("FAIL fair_w%0d: got %h want %h", cyc - 1, obs, exp); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] exp_w [$];
    logic [XLEN+SRCW:0] exp;
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      src_valid = (c < 6) ? 4'b0010 : 4'b0000;
      src_word[1*XLEN +: XLEN] = 32'hB100_0000 + 32'(c);
      step();
      if (c >= 1) begin
        n_cmp++;
        if (obs !== {1'b1, 2'd1, 32'hB100_0000}) begin
          n_err++; $display("FAIL bp_hold_c%0d: got %h want %h", c, obs, {1'b1, 2'd1, 32'hB100_0000});
        end
      end
    end
    src_valid = '0;
    n_cmp++;
    if (overflow !== 4'b0010) begin n_err++; $display("FAIL bp_ovf: got %b want 0010", overflow); end
    exp_w = '{32'hB100_0001, 32'hB100_0002, 32'hB100_0003, 32'hB100_0004};
`ifdef TRDB_ARB_OVERFLOW_MARKER_EN
    exp_w.push_back(32'hFFFF_FF01);
`endif
    out_ready = 1'b1;
    foreach (exp_w[k]) begin
      step();
      exp = {1'b1, 2'd1, exp_w[k]};
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL bp_drain%0d: got %h want %h", k, obs, exp); end
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_end: got valid %b want 0", out_valid); end
    n_cmp++;
    if (overflow !== 4'b0010) begin n_err++; $display("FAIL bp_ovf_hold: got %b want 0010", overflow); end
  endtask

  task automatic test_full_pop();
    logic [XLEN+SRCW:0] exp;
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      src_valid = 4'b0001;
      src_word[0 +: XLEN] = 32'hC000_0000 + 32'(c);
      step();
    end
    n_cmp++;
    if (obs !== {1'b1, 2'd0, 32'hC000_0000}) begin
      n_err++; $display("FAIL fp_pre: got %h want %h", obs, {1'b1, 2'd0, 32'hC000_0000});
    end
    out_ready = 1'b1;
    src_word[0 +: XLEN] = 32'hC000_0005;
    step();
    src_valid = '0;
    n_cmp++;
    if (overflow !== 4'b0000) begin n_err++; $display("FAIL fp_ovf: got %b want 0000", overflow); end
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step();
      exp = {1'b1, 2'd0, 32'hC000_0000 + 32'(k)};
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL fp_w%0d: got %h want %h", k, obs, exp); end
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL fp_end: got valid %b want 0", out_valid); end
  endtask

  task automatic test_clear();
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      src_valid = 4'b1010;
      src_word[1*XLEN +: XLEN] = 32'hE100_0000 + 32'(c);
      src_word[3*XLEN +: XLEN] = 32'hE300_0000 + 32'(c);
      step();
    end
    src_valid = '0;
    n_cmp++;
    if (overflow !== 4'b1010) begin n_err++; $display("FAIL clr_pre: got %b want 1010", overflow); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++;
    if (overflow !== 4'b0000) begin n_err++; $display("FAIL clr_plain: got %b want 0000", overflow); end
    clear = 1'b1;
    src_valid = 4'b1000;
    step();
    clear = 1'b0;
    src_valid = '0;
    n_cmp++;
    if (overflow !== 4'b1000) begin n_err++; $display("FAIL clr_setwins: got %b want 1000", overflow); end
    step();
    n_cmp++;
    if (overflow !== 4'b1000) begin n_err++; $display("FAIL clr_sticky: got %b want 1000", overflow); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL rm_out: got %h want 0", obs); end
    n_cmp++;
    if (overflow !== 4'b0000) begin n_err++; $display("FAIL rm_ovf: got %b want 0000", overflow); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    src_valid = 4'b1000;
    src_word[3*XLEN +: XLEN] = 32'hD00D_0003;
    step();
    src_valid = '0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_t1: got valid %b want 0", out_valid); end
    step();
    n_cmp++;
    if (obs !== {1'b1, 2'd3, 32'hD00D_0003}) begin
      n_err++; $display("FAIL rm_t2: got %h want %h", obs, {1'b1, 2'd3, 32'hD00D_0003});
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_stale%0d: got valid %b want 0", k, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_full_pop();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trdb_stream_arbiter.md
Name: trdb_stream_arbiter

Overview:
Shares one trace output stream between NSRC trace debugger instances, e.g. one per core in a cluster. Each source drives packet_word / packet_word_valid with no backpressure. The block buffers each source in a small FIFO and round-robin arbitrates the FIFOs onto a single valid/ready output toward the trace sink (memory writer or off-chip port). Overflow is tracked per source.

Parameters:
NSRC, 4, number of trace debugger sources (≥2)
XLEN, 32, packet word width (matches trdb_pkg XLEN)
FIFO_DEPTH, 4, per-source FIFO entries (power of 2, ≥2)
SRCW, max(1,$clog2(NSRC)), source index width (derived, localparam)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
src_word_i  in  NSRC*XLEN  packet words; source i at bits [i*XLEN +: XLEN]
src_valid_i  in  NSRC  per-source packet_word_valid; no ready returned
out_word_o  out  XLEN  arbitrated word
out_src_o  out  SRCW  index of source that produced out_word_o
out_valid_o  out  1  output word valid
out_ready_i  in  1  sink accepts word
overflow_o  out  NSRC  sticky per-source overflow flag
clear_i  in  1  clears overflow_o (and pending markers); FIFOs untouched

Behaviour:
- Reset: all registers cleared on the rising clk_i edge with rst_ni=0. FIFOs empty; RR pointer=0; out_valid_o=0, out_word_o=0, out_src_o=0, overflow_o=0. Reset mid-transfer discards all buffered words; a held out_valid_o drops to 0.
- Push: source i writes its FIFO when src_valid_i[i]=1 and FIFO i has space. Space exists when not full, or when full and FIFO i is popped in the same cycle (simultaneous pop frees the slot).
- Drop: push with no space → word discarded, overflow_o[i] set next cycle and held until clear_i or reset. clear_i and a new drop in the same cycle → overflow_o[i]=1 (set wins).
- Output register: a single stage, loaded when out_valid_o=0 or out_ready_i=1.
  - When loaded and any FIFO is non-empty, grant the first non-empty FIFO at or after the RR pointer (wrapping modulo NSRC). Pop it, register word and index, set out_valid_o=1, and set the RR pointer to grant+1 mod NSRC.
  - When loaded and all FIFOs are empty, out_valid_o←0.
- Handshake: out_word_o/out_src_o stable while out_valid_o=1 and out_ready_i=0. Transfer occurs on out_valid_o & out_ready_i.
- Throughput and latency:
  - Full throughput of 1 word/cycle with out_ready_i held high.
  - Word pushed in cycle t appears on output in cycle t+2 at the earliest (empty FIFOs, idle output).
- Ordering: per-source order is preserved; no ordering guarantee across sources.
- Fairness: with all FIFOs non-empty and ready=1, grants cycle 0,1,…,NSRC-1,0…

Optional Feature:
Macro TRDB_ARB_OVERFLOW_MARKER_EN.
- Defined:
  - A drop on source i also sets pending_marker[i].
  - In the first later cycle FIFO i has space, the marker word {{(XLEN-8){1'b1}}, 8'(i)} is pushed into FIFO i instead of any incoming word. A coincident incoming word is dropped; it keeps overflow_o[i]=1 but does not re-arm the marker.
  - Marker then flows like a normal word with out_src_o=i.
  - clear_i clears pending_marker.
- Undefined: no marker logic; dropped words vanish silently, only overflow_o reports them.

Test Plan:
- Single source: src_valid_i[2]=1 for one cycle with word 0x1234_5678, out_ready_i=1 → 2 cycles later out_valid_o=1, out_word_o=0x1234_5678, out_src_o=2, for exactly one cycle; overflow_o=0.
- Fairness: all 4 sources push 3 words each in the same cycles, ready=1 → output source order 0,1,2,3,0,1,2,3,0,1,2,3, per-source word order preserved, no gaps after first word.
- Backpressure: out_ready_i=0 for 10 cycles while out_valid_o=1 → out_word_o/out_src_o unchanged. Source 1 pushes 6 words → FIFO holds 4, remaining 1 dropped (1 word sits in output reg), overflow_o[1]=1. After ready=1, exactly 5 words out in order. With marker enabled, marker 0xFFFF_FF01 follows them.
- Full+pop same cycle: FIFO 0 full, ready=1 popping FIFO 0 while source 0 pushes → word accepted, overflow_o[0] stays 0.
- Clear: overflow_o=4'b1010, pulse clear_i with no drops → overflow_o=0 next cycle. clear_i coincident with a drop on source 3 → overflow_o[3]=1.
- Reset mid-stream: assert rst_ni=0 with FIFOs partially full and out_valid_o=1 → next cycle out_valid_o=0, overflow_o=0. After release, a new single push appears with latency 2, and no stale words appear.
